synch_ctrl: RTL and testbench

Sequencer for the receiver's preamble/timing-synchronisation datapath. It arms the synchroniser, flushes the metric delay lines, and masks the warm-up interval until they hold valid history. It then bounds the search with a timeout and captures the frequency-offset word, and holds the synchroniser idle while a configured number of OFDM symbols is passed downstream before re-arming. It sits between the receiver top-level control and the synchroniser, driving its run and datapath-reset inputs.

---
 rtl/synch_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_synch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/synch_ctrl.sv
// synch_ctrl: sequencer for the preamble/timing synchroniser. It flushes and warms
// the metric delay lines, bounds the search, captures the frequency word and passes a burst.
module synch_ctrl #(
    parameter int SYM_LEN   = 320,
    parameter int WARM_LEN  = 192,
    parameter int SEARCH_TO = 16384,
    parameter int EST_TO    = 64,
    parameter int FLUSH_CYC = 4,
    parameter int CNT_W     = 20
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        enable,
    input  logic [7:0]  frame_len,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        out_stb,
    input  logic        ACK_I,
    input  logic        syn_done,
    input  logic        fre_val,
    input  logic [31:0] fre_dat,
    output logic        syn_run,
    output logic        dp_rst,
    output logic [31:0] fre_o,
    output logic        fre_o_val,
    output logic        frame_done,
    output logic        timeout,
    output logic        busy,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_WARM   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_EST    = 3'd4,
        ST_PASS   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARM_LEN - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TO - 1);
    localparam logic [CNT_W-1:0] EST_LAST    = CNT_W'(EST_TO - 1);
    localparam logic [CNT_W-1:0] SYM_LEN_C   = CNT_W'(SYM_LEN);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] target_nxt_s;
    logic [CNT_W-1:0] burst_len_s;
    logic [8:0]       nsym_s;
    logic             acc_s;
    logic             xfer_s;
    logic             cap_s;
    logic             done_s;
    logic             tmo_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    assign acc_s  = CYC_I & STB_I;
    assign xfer_s = out_stb & ACK_I;

    // Burst length in samples; a frame_len of zero encodes the maximum of 256 symbols.
    always_comb begin
        if (frame_len == 8'd0) begin
            nsym_s = 9'd256;
        end else begin
            nsym_s = {1'b0, frame_len};
        end
        burst_len_s = CNT_W'(nsym_s) * SYM_LEN_C;
    end

    // Next-state, counter and event decode; enable drops abort WARM/SEARCH but never a burst.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        target_nxt_s = target_r;
        cap_s        = 1'b0;
        done_s       = 1'b0;
        tmo_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s  = ST_FLUSH;
                    cnt_nxt_s    = '0;
                    target_nxt_s = burst_len_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r >= FLUSH_LAST) begin
                    state_nxt_s = ST_WARM;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_WARM: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else if (syn_done) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = '0;
                end else if (acc_s) begin
                    if (cnt_r >= WARM_LAST) begin
                        state_nxt_s = ST_SEARCH;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = sat_inc(cnt_r);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_SEARCH: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else if (syn_done) begin
                    // A word already valid alongside the detection is taken straight away.
                    cnt_nxt_s = '0;
                    if (fre_val) begin
                        cap_s       = 1'b1;
                        state_nxt_s = ST_PASS;
                    end else begin
                        state_nxt_s = ST_EST;
                    end
                end else if (acc_s) begin
                    if (cnt_r >= SEARCH_LAST) begin
                        tmo_s       = 1'b1;
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = sat_inc(cnt_r);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_EST: begin
                if (fre_val) begin
                    cap_s       = 1'b1;
                    state_nxt_s = ST_PASS;
                    cnt_nxt_s   = '0;
                end else if (cnt_r >= EST_LAST) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_PASS: begin
                if (xfer_s) begin
                    if (sat_inc(cnt_r) >= target_r) begin
                        done_s      = 1'b1;
                        cnt_nxt_s   = '0;
                        state_nxt_s = enable ? ST_FLUSH : ST_IDLE;
                    end else begin
                        cnt_nxt_s = sat_inc(cnt_r);
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counters and all outputs registered from the decoded next state.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            target_r   <= '0;
            syn_run    <= 1'b0;
            dp_rst     <= 1'b0;
            busy       <= 1'b0;
            state_o    <= 3'd0;
            fre_o      <= 32'd0;
            fre_o_val  <= 1'b0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            target_r   <= target_nxt_s;
            syn_run    <= (state_nxt_s == ST_WARM) || (state_nxt_s == ST_SEARCH);
            dp_rst     <= (state_nxt_s == ST_FLUSH);
            busy       <= (state_nxt_s != ST_IDLE);
            state_o    <= state_nxt_s;
            fre_o_val  <= cap_s;
            frame_done <= done_s;
            timeout    <= tmo_s;
            if (cap_s) begin
                fre_o <= fre_dat;
            end
        end
    end

endmodule

// File: tb/tb_synch_ctrl.sv
// Table-driven bench for synch_ctrl with scaled-down lengths so every corner,
// including the 256-symbol burst, fits in a short run.
module tb_synch_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_FLUSH = 3'd1, S_WARM = 3'd2,
                           S_SEARCH = 3'd3, S_EST = 3'd4, S_PASS = 3'd5, S_ANY = 3'd7;
    localparam logic [31:0] F0 = 32'h0000_0000, F1 = 32'h0012_FF80, F2 = 32'hA5A5_5A5A,
                            F3 = 32'h0000_0001, F4 = 32'h1234_5678;

    logic        CLK_I, RST_I, enable, CYC_I, STB_I, out_stb, ACK_I, syn_done, fre_val;
    logic [7:0]  frame_len;
    logic [31:0] fre_dat, fre_o;
    logic        syn_run, dp_rst, fre_o_val, frame_done, timeout, busy;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;

    synch_ctrl #(
        .SYM_LEN(32), .WARM_LEN(16), .SEARCH_TO(50), .EST_TO(64), .FLUSH_CYC(4), .CNT_W(20)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .enable(enable), .frame_len(frame_len),
        .CYC_I(CYC_I), .STB_I(STB_I), .out_stb(out_stb), .ACK_I(ACK_I),
        .syn_done(syn_done), .fre_val(fre_val), .fre_dat(fre_dat),
        .syn_run(syn_run), .dp_rst(dp_rst), .fre_o(fre_o), .fre_o_val(fre_o_val),
        .frame_done(frame_done), .timeout(timeout), .busy(busy), .state_o(state_o)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    typedef struct {
        int          rep;
        logic        en;
        logic [7:0]  flen;
        logic        smp;
        logic        xfr;
        logic        sd;
        logic        fv;
        logic [31:0] fdat;
        logic [2:0]  st;
        logic        fval;
        logic        to;
        logic        done;
        logic [31:0] fo;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;
    logic pulse_seen;

    function automatic vec_t v(input int rep, input logic en, input logic [7:0] flen,
                               input logic smp, input logic xfr, input logic sd, input logic fv,
                               input logic [31:0] fdat, input logic [2:0] st, input logic fval,
                               input logic to, input logic done, input logic [31:0] fo);
        vec_t r;
        r.rep = rep; r.en = en; r.flen = flen; r.smp = smp; r.xfr = xfr; r.sd = sd;
        r.fv = fv; r.fdat = fdat; r.st = st; r.fval = fval; r.to = to; r.done = done; r.fo = fo;
        return r;
    endfunction

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk_all_zero(input int idx);
        chk(idx, "state_o", state_o, 32'd0);
        chk(idx, "busy", busy, 32'd0);
        chk(idx, "syn_run", syn_run, 32'd0);
        chk(idx, "dp_rst", dp_rst, 32'd0);
        chk(idx, "fre_o", fre_o, 32'd0);
        chk(idx, "pulses", {fre_o_val, frame_done, timeout}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_I = 1'b0; enable = 1'b0; frame_len = 8'd0; CYC_I = 1'b0; STB_I = 1'b0;
        out_stb = 1'b0; ACK_I = 1'b0; syn_done = 1'b0; fre_val = 1'b0; fre_dat = 32'd0;

        //            rep en flen smp xfr sd fv fdat  state    fval to done fo
        // Main burst: flen=2 (64 transfers), detection at SEARCH sample 11.
        vecs.push_back(v(1,    0, 8'd0, 0, 0, 0, 0, F0, S_IDLE,   0, 0, 0, F0));
        vecs.push_back(v(1,    1, 8'd2, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F0));
        vecs.push_back(v(3,    1, 8'd0, 1, 1, 0, 0, F0, S_FLUSH,  0, 0, 0, F0));
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F0));
        vecs.push_back(v(15,   1, 8'd0, 1, 0, 0, 0, F0, S_WARM,   0, 0, 0, F0));
        vecs.push_back(v(1,    1, 8'd0, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F0));
        vecs.push_back(v(10,   1, 8'd0, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F0));
        vecs.push_back(v(5,    1, 8'd0, 0, 1, 0, 0, F0, S_SEARCH, 0, 0, 0, F0));
        vecs.push_back(v(1,    1, 8'd0, 1, 0, 1, 0, F0, S_EST,    0, 0, 0, F0));
        vecs.push_back(v(2,    1, 8'd0, 1, 1, 0, 0, F0, S_EST,    0, 0, 0, F0));
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 0, 1, F1, S_PASS,   1, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd0, 0, 1, 0, 0, F0, S_PASS,   0, 0, 0, F1));
        vecs.push_back(v(62,   1, 8'd0, 0, 1, 0, 0, F0, S_PASS,   0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd0, 0, 1, 0, 0, F0, S_FLUSH,  0, 0, 1, F1));
        // Flush runs to completion with enable low, then WARM aborts to IDLE.
        vecs.push_back(v(1,    0, 8'd0, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F1));
        vecs.push_back(v(3,    0, 8'd0, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        vecs.push_back(v(1,    0, 8'd0, 0, 0, 0, 0, F0, S_IDLE,   0, 0, 0, F1));
        // Spurious detection in WARM, then a full SEARCH timeout.
        vecs.push_back(v(1,    1, 8'd1, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F1));
        vecs.push_back(v(4,    1, 8'd1, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        vecs.push_back(v(5,    1, 8'd1, 1, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 1, 0, 1, 0, F0, S_FLUSH,  0, 0, 0, F1));
        vecs.push_back(v(4,    1, 8'd1, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        vecs.push_back(v(16,   1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(49,   1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 1, 0, 0, 0, F0, S_FLUSH,  0, 1, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F1));
        vecs.push_back(v(3,    1, 8'd1, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        // Enable dropped mid-SEARCH.
        vecs.push_back(v(16,   1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(3,    1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(1,    0, 8'd1, 1, 0, 0, 0, F0, S_IDLE,   0, 0, 0, F1));
        // Detection on the last search sample wins, then EST times out.
        vecs.push_back(v(1,    1, 8'd1, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F1));
        vecs.push_back(v(4,    1, 8'd1, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        vecs.push_back(v(16,   1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(49,   1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 1, 0, 1, 0, F0, S_EST,    0, 0, 0, F1));
        vecs.push_back(v(63,   1, 8'd1, 0, 0, 0, 0, F0, S_EST,    0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 0, 0, 0, 0, F0, S_FLUSH,  0, 1, 0, F1));
        // Word valid together with detection, then enable dropped mid-PASS.
        vecs.push_back(v(3,    1, 8'd1, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F1));
        vecs.push_back(v(16,   1, 8'd1, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F1));
        vecs.push_back(v(1,    1, 8'd1, 1, 0, 1, 1, F2, S_ANY,    1, 0, 0, F2));
        vecs.push_back(v(1,    1, 8'd1, 0, 0, 0, 0, F0, S_PASS,   0, 0, 0, F2));
        vecs.push_back(v(31,   0, 8'd1, 0, 1, 0, 0, F0, S_PASS,   0, 0, 0, F2));
        vecs.push_back(v(1,    0, 8'd1, 0, 1, 0, 0, F0, S_IDLE,   0, 0, 1, F2));
        // frame_len=0: 256 symbols of 32 samples = 8192 transfers.
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 0, 0, F0, S_FLUSH,  0, 0, 0, F2));
        vecs.push_back(v(4,    1, 8'd0, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F2));
        vecs.push_back(v(16,   1, 8'd0, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F2));
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 1, 0, F0, S_EST,    0, 0, 0, F2));
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 0, 1, F3, S_PASS,   1, 0, 0, F3));
        vecs.push_back(v(8191, 1, 8'd0, 0, 1, 0, 0, F0, S_PASS,   0, 0, 0, F3));
        vecs.push_back(v(1,    1, 8'd0, 0, 1, 0, 0, F0, S_FLUSH,  0, 0, 1, F3));
        // Into PASS again for the reset-mid-burst sequence.
        vecs.push_back(v(4,    1, 8'd0, 0, 0, 0, 0, F0, S_WARM,   0, 0, 0, F3));
        vecs.push_back(v(16,   1, 8'd0, 1, 0, 0, 0, F0, S_SEARCH, 0, 0, 0, F3));
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 1, 0, F0, S_EST,    0, 0, 0, F3));
        vecs.push_back(v(1,    1, 8'd0, 0, 0, 0, 1, F4, S_PASS,   1, 0, 0, F4));
        vecs.push_back(v(5,    1, 8'd0, 0, 1, 0, 0, F0, S_PASS,   0, 0, 0, F4));

        #3;
        chk_all_zero(-1);
        RST_I = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            enable = cur.en; frame_len = cur.flen; CYC_I = cur.smp; STB_I = cur.smp;
            out_stb = cur.xfr; ACK_I = cur.xfr; syn_done = cur.sd; fre_val = cur.fv;
            fre_dat = cur.fdat;
            pulse_seen = 1'b0;
            for (int r = 0; r < cur.rep; r++) begin
                step();
                if (r < cur.rep - 1) begin
                    pulse_seen = pulse_seen | fre_o_val | timeout | frame_done;
                end
            end
            chk(i, "early_pulse", pulse_seen, 32'd0);
            if (cur.st != S_ANY) begin
                chk(i, "state_o", state_o, cur.st);
                chk(i, "busy", busy, cur.st != S_IDLE);
                chk(i, "syn_run", syn_run, (cur.st == S_WARM) || (cur.st == S_SEARCH));
                chk(i, "dp_rst", dp_rst, cur.st == S_FLUSH);
            end
            chk(i, "fre_o_val", fre_o_val, cur.fval);
            chk(i, "timeout", timeout, cur.to);
            chk(i, "frame_done", frame_done, cur.done);
            chk(i, "fre_o", fre_o, cur.fo);
        end

        // Asynchronous reset in the middle of PASS clears everything at once.
        CYC_I = 1'b0; STB_I = 1'b0; syn_done = 1'b0; fre_val = 1'b0;
        #2;
        RST_I = 1'b0;
        #1;
        chk_all_zero(100);
        step();
        chk_all_zero(101);
        enable = 1'b0;
        RST_I = 1'b1;
        step();
        chk_all_zero(102);
        enable = 1'b1;
        frame_len = 8'd1;
        step();
        chk(103, "state_o", state_o, S_FLUSH);
        chk(103, "dp_rst", dp_rst, 32'd1);
        chk(103, "fre_o", fre_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
